// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the CPU run/step sequencer: state codes and the
// default divider / debounce terminal counts for a 50 MHz board clock.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    // 250 ms slow tick at 50 MHz
    localparam int unsigned TICK_MAX_DEF = 32'd12499999;
    // 10 ms debounce at 50 MHz
    localparam int unsigned DEB_MAX_DEF  = 32'd499999;

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Turns a raw asynchronous push-button into a one-cycle press pulse.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_btn    raw button level (asynchronous)
//   o_pulse  one-cycle pulse on each accepted press
// Chain: 2-flop synchroniser -> debounce -> registered rising-edge detect.
module btn_conditioner
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DEB_MAX = DEB_MAX_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned     DebW    = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam logic [DebW-1:0] DebTerm = DebW'(DEB_MAX);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic            r_pulse;
    logic [DebW-1:0] r_deb_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Count consecutive cycles of disagreement; the level flips only
            // once DEB_MAX+1 of them have been seen, any agreement restarts.
            if (r_sync2 == r_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DebTerm) begin
                r_level   <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DebW'(1);
            end
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step sequencer generating the one-cycle Go enable for the 8-bit CPU.
// Modes: slow tick (divided clock), turbo (every cycle), single step, with an
// instruction-address breakpoint that halts before the matching instruction.
// Ports:
//   i_clk, i_rst_n          clock / asynchronous active-low reset
//   i_turbo                 Turbo switch (asynchronous)
//   i_run_btn, i_step_btn   raw buttons (asynchronous)
//   i_brk_en, i_brk_addr    breakpoint enable and address
//   i_ip                    address of the instruction the next Go executes
//   o_go                    instruction-cycle enable
//   o_halted                high in HALT
//   o_brk_hit               sticky breakpoint-halt flag
//   o_state                 current state code
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TICK_MAX  = TICK_MAX_DEF,
    parameter int unsigned DEB_MAX   = DEB_MAX_DEF,
    parameter bit          START_RUN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_turbo,
    input  logic       i_run_btn,
    input  logic       i_step_btn,
    input  logic       i_brk_en,
    input  logic [7:0] i_brk_addr,
    input  logic [7:0] i_ip,
    output logic       o_go,
    output logic       o_halted,
    output logic       o_brk_hit,
    output logic [1:0] o_state
);

    localparam int unsigned     CntW    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntTerm = CntW'(TICK_MAX);
    localparam state_e          StReset = START_RUN ? ST_RUN : ST_HALT;

    logic [CntW-1:0] r_cnt;
    logic            r_turbo1;
    logic            r_turbo_s;
    state_e          r_state;
    logic            r_skip;
    logic            r_brk_hit;

    state_e          w_state_next;
    logic            w_skip_next;
    logic            w_brk_hit_next;
    logic            w_run_p;
    logic            w_step_p;
    logic            w_tick;
    logic            w_brk;
    logic            w_go;

    btn_conditioner #(
        .DEB_MAX (DEB_MAX)
    ) u_run_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_run_btn),
        .o_pulse (w_run_p)
    );

    btn_conditioner #(
        .DEB_MAX (DEB_MAX)
    ) u_step_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_step_btn),
        .o_pulse (w_step_p)
    );

    // Free-running divider; deliberately never cleared on mode changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_turbo1  <= 1'b0;
            r_turbo_s <= 1'b0;
        end else begin
            r_cnt     <= (r_cnt == CntTerm) ? '0 : r_cnt + CntW'(1);
            r_turbo1  <= i_turbo;
            r_turbo_s <= r_turbo1;
        end
    end

    assign w_tick = (r_cnt == '0) | r_turbo_s;
    // skip lets a resume at the breakpoint address execute that instruction once
    assign w_brk  = i_brk_en & (i_ip == i_brk_addr) & ~r_skip;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StReset;
            r_skip    <= 1'b0;
            r_brk_hit <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_skip    <= w_skip_next;
            r_brk_hit <= w_brk_hit_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_skip_next    = r_skip;
        w_brk_hit_next = r_brk_hit;
        case (r_state)
            ST_HALT: begin
                if (w_run_p) begin
                    w_state_next   = ST_RUN;
                    w_brk_hit_next = 1'b0;
                    w_skip_next    = 1'b1;
                end else if (w_step_p) begin
                    w_state_next   = ST_STEP;
                    w_brk_hit_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_run_p) begin
                    w_state_next = ST_HALT;
                end else if (w_brk) begin
                    w_state_next   = ST_HALT;
                    w_brk_hit_next = 1'b1;
                end else if (w_tick) begin
                    w_skip_next = 1'b0;
                end
            end
            ST_STEP: w_state_next = ST_HALT;
            default: w_state_next = ST_HALT;
        endcase
    end

    // Output logic
    always_comb begin
        w_go = 1'b0;
        case (r_state)
            ST_RUN:  w_go = ~w_run_p & ~w_brk & w_tick;
            ST_STEP: w_go = 1'b1;
            default: w_go = 1'b0;
        endcase
    end

    // Reset gates Go combinationally so it drops within the asserting cycle.
    assign o_go      = w_go & i_rst_n;
    assign o_halted  = (r_state == ST_HALT);
    assign o_brk_hit = r_brk_hit;
    assign o_state   = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Scoreboard bench: each cycle where Go is required pushes the current model IP,
// each observed Go pops and compares it.
module tb_cpu_run_ctrl;

    logic       clk;
    logic       rst_n;
    logic       turbo;
    logic       run_btn;
    logic       step_btn;
    logic       brk_en;
    logic [7:0] brk_addr;
    logic [7:0] ip = 8'd0;
    logic       go;
    logic       halted;
    logic       brk_hit;
    logic [1:0] state;

    logic       ip_load;
    logic [7:0] ip_val;
    int         mcnt;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         errors = 0;
    int         checks = 0;

    cpu_run_ctrl #(
        .TICK_MAX  (3),
        .DEB_MAX   (2),
        .START_RUN (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_turbo    (turbo),
        .i_run_btn  (run_btn),
        .i_step_btn (step_btn),
        .i_brk_en   (brk_en),
        .i_brk_addr (brk_addr),
        .i_ip       (ip),
        .o_go       (go),
        .o_halted   (halted),
        .o_brk_hit  (brk_hit),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU IP model: advances on each Go
    always @(posedge clk) begin
        if (ip_load) ip <= ip_val;
        else if (go) ip <= ip + 8'd1;
    end

    // Reference slow-tick phase, 0..3
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 0;
        else mcnt <= (mcnt == 3) ? 0 : mcnt + 1;
    end

    task automatic pop_go(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_ip: Go at ip=%0d, no Go required", name, ip);
        end else begin
            e = exp_q.pop_front();
            if (ip !== e) begin
                errors++;
                $display("FAIL %s_ip: Go at ip=%0d, required ip=%0d", name, ip, e);
            end
        end
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d required Go(s) never seen, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; turbo = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
        brk_en = 1'b0; brk_addr = 8'h00; ip_load = 1'b0; ip_val = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL reset_go: go=%b want 0", go); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: %b want 0", halted); end
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL reset_state: %0d want 1", state); end
        checks++;
        if (brk_hit !== 1'b0) begin errors++; $display("FAIL reset_brkhit: %b want 0", brk_hit); end
        rst_n = 1'b1;
    endtask

    task automatic test_slow_tick();
        logic want;
        for (int j = 0; j < 12; j++) begin
            want = (mcnt == 0);
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL slow_go[%0d]: go=%b want %b", j, go, want); end
            if (go === 1'b1) pop_go("slow");
            @(posedge clk); #1;
        end
        drain("slow");
        checks++;
        if (ip !== 8'd3) begin errors++; $display("FAIL slow_ipend: ip=%0d want 3", ip); end
    endtask

    task automatic test_turbo();
        logic want;
        turbo = 1'b1;
        for (int j = 0; j < 8; j++) begin
            want = (j >= 2) || (mcnt == 0);
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL turbo_on_go[%0d]: go=%b want %b", j, go, want); end
            if (go === 1'b1) pop_go("turbo_on");
            @(posedge clk); #1;
        end
        turbo = 1'b0;
        for (int j = 0; j < 10; j++) begin
            want = (j < 2) || (mcnt == 0);
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL turbo_off_go[%0d]: go=%b want %b", j, go, want); end
            if (go === 1'b1) pop_go("turbo_off");
            @(posedge clk); #1;
        end
        drain("turbo");
    endtask

    task automatic test_breakpoint();
        logic want;
        logic hit;
        hit = 1'b0;
        brk_en = 1'b1; brk_addr = 8'h05; turbo = 1'b1;
        for (int j = 0; j < 400 && !hit; j++) begin
            hit  = (ip == 8'd5);
            want = !hit && ((j >= 2) || (mcnt == 0));
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL brk_go[%0d]: go=%b want %b ip=%0d", j, go, want, ip); end
            if (go === 1'b1) pop_go("brk");
            @(posedge clk); #1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL brk_timeout: ip=%0d never reached 5", ip); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (go !== 1'b0) begin errors++; $display("FAIL brk_hold_go: go=%b want 0", go); end
        end
        @(posedge clk); #1;
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL brk_halted: %b want 1", halted); end
        checks++;
        if (brk_hit !== 1'b1) begin errors++; $display("FAIL brk_hit: %b want 1", brk_hit); end
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL brk_state: %0d want 0", state); end
        checks++;
        if (ip !== 8'd5) begin errors++; $display("FAIL brk_ip: ip=%0d want 5", ip); end
        drain("brk");
    endtask

    task automatic test_step();
        logic want;
        step_btn = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j == 4) step_btn = 1'b0;
            want = (j == 7);
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL step_go[%0d]: go=%b want %b", j, go, want); end
            if (go === 1'b1) pop_go("step");
            @(posedge clk); #1;
        end
        drain("step");
        checks++;
        if (ip !== 8'd6) begin errors++; $display("FAIL step_ip: ip=%0d want 6", ip); end
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL step_state: %0d want 0", state); end
        checks++;
        if (brk_hit !== 1'b0) begin errors++; $display("FAIL step_brkhit: %b want 0", brk_hit); end
    endtask

    task automatic test_glitch();
        step_btn = 1'b1;
        for (int j = 0; j < 15; j++) begin
            if (j == 2) step_btn = 1'b0;
            @(negedge clk);
            checks++;
            if (go !== 1'b0) begin errors++; $display("FAIL glitch_go[%0d]: go=%b want 0", j, go); end
            if (go === 1'b1) pop_go("glitch");
            @(posedge clk); #1;
        end
        checks++;
        if (ip !== 8'd6) begin errors++; $display("FAIL glitch_ip: ip=%0d want 6", ip); end
    endtask

    task automatic test_skip_resume();
        logic want;
        logic hit;
        ip_val = 8'd5; ip_load = 1'b1;
        @(posedge clk); #1;
        ip_load = 1'b0;
        hit = 1'b0;
        run_btn = 1'b1;
        for (int j = 0; j < 400 && !hit; j++) begin
            if (j == 4) run_btn = 1'b0;
            hit  = (j > 7) && (ip == 8'd5);
            want = (j >= 7) && !hit;
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL skip_go[%0d]: go=%b want %b ip=%0d", j, go, want, ip); end
            if (go === 1'b1) pop_go("skip");
            @(posedge clk); #1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL skip_timeout: ip=%0d never returned to 5", ip); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL skip_halted: %b want 1", halted); end
        checks++;
        if (brk_hit !== 1'b1) begin errors++; $display("FAIL skip_brkhit: %b want 1", brk_hit); end
        drain("skip");
    endtask

    task automatic test_reset_midrun();
        logic want;
        run_btn = 1'b1;
        for (int j = 0; j < 17; j++) begin
            if (j == 4) run_btn = 1'b0;
            want = (j >= 7);
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL rerun_go[%0d]: go=%b want %b", j, go, want); end
            if (go === 1'b1) pop_go("rerun");
            @(posedge clk); #1;
        end
        drain("rerun");
        checks++;
        if (go !== 1'b1) begin errors++; $display("FAIL midrun_pre_go: go=%b want 1", go); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL midrun_reset_go: go=%b want 0", go); end
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL midrun_reset_state: %0d want 1", state); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Turbo synchroniser restarts from 0, so the first cycles follow cnt from 0
        for (int j = 0; j < 3; j++) begin
            want = (j >= 2) || (mcnt == 0);
            if (want) exp_q.push_back(ip);
            @(negedge clk);
            checks++;
            if (go !== want) begin errors++; $display("FAIL postreset_go[%0d]: go=%b want %b", j, go, want); end
            if (go === 1'b1) pop_go("postreset");
            @(posedge clk); #1;
        end
        drain("postreset");
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL postreset_halted: %b want 0", halted); end
    endtask

    initial begin
        test_reset();
        test_slow_tick();
        test_turbo();
        test_breakpoint();
        test_step();
        test_glitch();
        test_skip_resume();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
